// File: rtl/ddr_arbiter.sv
// Arbitrates a display read port and a draw write port onto a single DDR controller.
// Reads win by default; a waiting write is forced through after STARVE_LIMIT consecutive reads.
module ddr_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk133_p,
    input  logic        rst,
    input  logic        dispReq,
    input  logic [23:0] dispAddress,
    output logic        dispAck,
    output logic [15:0] dispData,
    input  logic        drawReq,
    input  logic [23:0] drawAddress,
    input  logic [15:0] drawData,
    output logic        drawAck,
    output logic        ddrRead,
    output logic [23:0] ddrReadAddress,
    input  logic        ddrReadAcknowledge,
    input  logic [15:0] ddrReadData,
    output logic        ddrWrite,
    output logic [23:0] ddrWriteAddress,
    output logic [15:0] ddrWriteData,
    input  logic        ddrWriteAcknowledge,
    output logic        timeoutError
);

    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam int TW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        READ_RELEASE,
        WRITE_REQ,
        WRITE_RELEASE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [23:0]   rd_addr_q, rd_addr_d;
    logic [23:0]   wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic [15:0]   disp_data_q, disp_data_d;
    logic          disp_ack_q, disp_ack_d;
    logic          draw_ack_q, draw_ack_d;
    logic          tmo_err_q, tmo_err_d;
    logic          tmo_hit;
    logic          ddr_busy;

    assign tmo_hit  = (tmo_q >= TW'(TIMEOUT - 1));
    assign ddr_busy = ddrReadAcknowledge | ddrWriteAcknowledge;

    always_ff @(posedge clk133_p) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            disp_data_q <= '0;
            disp_ack_q  <= 1'b0;
            draw_ack_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            disp_data_q <= disp_data_d;
            disp_ack_q  <= disp_ack_d;
            draw_ack_q  <= draw_ack_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        disp_data_d = disp_data_q;
        disp_ack_d  = 1'b0;
        draw_ack_d  = 1'b0;
        tmo_err_d   = tmo_err_q;

        // Counter saturates so a late ack cannot wrap it back below the abort threshold.
        if (state_q != IDLE && state_q != DONE && tmo_q != {TW{1'b1}}) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (!drawReq) begin
                    starve_d = '0;
                end
                // A leftover ack (e.g. after reset) must drain before any new request.
                if (!ddr_busy) begin
                    if (dispReq && (!drawReq || starve_q < SW'(STARVE_LIMIT))) begin
                        state_d   = READ_REQ;
                        rd_d      = 1'b1;
                        rd_addr_d = dispAddress;
                        if (drawReq && starve_q != {SW{1'b1}}) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (drawReq) begin
                        state_d   = WRITE_REQ;
                        wr_d      = 1'b1;
                        wr_addr_d = drawAddress;
                        wr_data_d = drawData;
                        starve_d  = '0;
                    end
                end
            end
            READ_REQ: begin
                if (ddrReadAcknowledge) begin
                    disp_data_d = ddrReadData;
                    rd_d        = 1'b0;
                    state_d     = READ_RELEASE;
                end else if (tmo_hit) begin
                    disp_data_d = '0;
                    rd_d        = 1'b0;
                    tmo_err_d   = 1'b1;
                    disp_ack_d  = 1'b1;
                    state_d     = DONE;
                end
            end
            READ_RELEASE: begin
                if (!ddrReadAcknowledge) begin
                    disp_ack_d = 1'b1;
                    state_d    = DONE;
                end else if (tmo_hit) begin
                    disp_data_d = '0;
                    tmo_err_d   = 1'b1;
                    disp_ack_d  = 1'b1;
                    state_d     = DONE;
                end
            end
            WRITE_REQ: begin
                if (ddrWriteAcknowledge) begin
                    wr_d    = 1'b0;
                    state_d = WRITE_RELEASE;
                end else if (tmo_hit) begin
                    wr_d       = 1'b0;
                    tmo_err_d  = 1'b1;
                    draw_ack_d = 1'b1;
                    state_d    = DONE;
                end
            end
            WRITE_RELEASE: begin
                if (!ddrWriteAcknowledge || tmo_hit) begin
                    tmo_err_d  = tmo_err_q | ddrWriteAcknowledge;
                    draw_ack_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // Client request is still high this cycle; only IDLE looks at it again.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    assign dispAck         = disp_ack_q;
    assign dispData        = disp_data_q;
    assign drawAck         = draw_ack_q;
    assign ddrRead         = rd_q;
    assign ddrReadAddress  = rd_addr_q;
    assign ddrWrite        = wr_q;
    assign ddrWriteAddress = wr_addr_q;
    assign ddrWriteData    = wr_data_q;
    assign timeoutError    = tmo_err_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: a small DDR controller model plus a negedge monitor
// for request overlap, ack pulse width and grant order.
module tb_ddr_arbiter;

    logic        clk133_p = 1'b0;
    logic        rst;
    logic        dispReq;
    logic [23:0] dispAddress;
    logic        dispAck;
    logic [15:0] dispData;
    logic        drawReq;
    logic [23:0] drawAddress;
    logic [15:0] drawData;
    logic        drawAck;
    logic        ddrRead;
    logic [23:0] ddrReadAddress;
    logic        ddrReadAcknowledge;
    logic [15:0] ddrReadData;
    logic        ddrWrite;
    logic [23:0] ddrWriteAddress;
    logic [15:0] ddrWriteData;
    logic        ddrWriteAcknowledge;
    logic        timeoutError;

    int vectors    = 0;
    int miscompares = 0;

    // DDR controller model
    logic        rd_ack_m = 1'b0;
    logic        wr_ack_m = 1'b0;
    logic        ack_hold = 1'b0;
    logic        never_ack = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rd_delay = 8;
    int          wr_delay = 8;
    logic [23:0] m_wr_addr = '0;
    logic [15:0] m_wr_data = '0;

    // Monitor state
    logic        prev_rd = 1'b0, prev_wr = 1'b0, prev_da = 1'b0, prev_wa = 1'b0;
    int          rd_high = 0;
    int          disp_ack_cnt = 0;
    int          draw_ack_cnt = 0;
    int          nlog = 0;
    logic        grant_log [0:15];

    always #5 clk133_p = ~clk133_p;

    assign ddrReadAcknowledge  = rd_ack_m | ack_hold;
    assign ddrWriteAcknowledge = wr_ack_m;

    ddr_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk133_p           (clk133_p),
        .rst                (rst),
        .dispReq            (dispReq),
        .dispAddress        (dispAddress),
        .dispAck            (dispAck),
        .dispData           (dispData),
        .drawReq            (drawReq),
        .drawAddress        (drawAddress),
        .drawData           (drawData),
        .drawAck            (drawAck),
        .ddrRead            (ddrRead),
        .ddrReadAddress     (ddrReadAddress),
        .ddrReadAcknowledge (ddrReadAcknowledge),
        .ddrReadData        (ddrReadData),
        .ddrWrite           (ddrWrite),
        .ddrWriteAddress    (ddrWriteAddress),
        .ddrWriteData       (ddrWriteData),
        .ddrWriteAcknowledge(ddrWriteAcknowledge),
        .timeoutError       (timeoutError)
    );

    always @(posedge clk133_p) begin
        if (ddrRead) begin
            rd_cnt <= rd_cnt + 1;
            if (!never_ack && rd_cnt + 1 >= rd_delay) rd_ack_m <= 1'b1;
        end else begin
            rd_cnt   <= 0;
            rd_ack_m <= 1'b0;
        end
        if (ddrWrite) begin
            wr_cnt <= wr_cnt + 1;
            if (!never_ack && wr_cnt + 1 >= wr_delay && !wr_ack_m) begin
                wr_ack_m  <= 1'b1;
                m_wr_addr <= ddrWriteAddress;
                m_wr_data <= ddrWriteData;
            end
        end else begin
            wr_cnt   <= 0;
            wr_ack_m <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk133_p) begin
        chk("rd_wr_overlap", {31'd0, ddrRead & ddrWrite}, 32'd0);
        chk("disp_ack_width", {31'd0, dispAck & prev_da}, 32'd0);
        chk("draw_ack_width", {31'd0, drawAck & prev_wa}, 32'd0);
        if (ddrRead) rd_high++;
        if (dispAck) disp_ack_cnt++;
        if (drawAck) draw_ack_cnt++;
        if (ddrRead && !prev_rd && nlog < 16) begin grant_log[nlog] = 1'b0; nlog++; end
        if (ddrWrite && !prev_wr && nlog < 16) begin grant_log[nlog] = 1'b1; nlog++; end
        prev_rd = ddrRead;
        prev_wr = ddrWrite;
        prev_da = dispAck;
        prev_wa = drawAck;
    end

    task automatic tick();
        @(posedge clk133_p);
        #1;
    endtask

    task automatic wait_ack(input bit draw, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (draw ? drawAck : dispAck) seen = 1'b1;
        end
    endtask

    initial begin
        bit          seen;
        logic [15:0] exp_seq;
        rst = 1'b1; dispReq = 1'b0; dispAddress = '0; drawReq = 1'b0;
        drawAddress = '0; drawData = '0; ddrReadData = '0;
        exp_seq = 16'b0000_0010_0001_0000;
        repeat (3) tick();
        chk("rst_dispAck", {31'd0, dispAck}, 32'd0);
        chk("rst_drawAck", {31'd0, drawAck}, 32'd0);
        chk("rst_ddrRead", {31'd0, ddrRead}, 32'd0);
        chk("rst_ddrWrite", {31'd0, ddrWrite}, 32'd0);
        chk("rst_timeoutError", {31'd0, timeoutError}, 32'd0);
        chk("rst_dispData", {16'd0, dispData}, 32'd0);
        chk("rst_rdAddr", {8'd0, ddrReadAddress}, 32'd0);
        chk("rst_wrAddr", {8'd0, ddrWriteAddress}, 32'd0);
        chk("rst_wrData", {16'd0, ddrWriteData}, 32'd0);
        rst = 1'b0;
        tick();

        // Single read, 8-cycle DDR latency
        rd_high = 0; disp_ack_cnt = 0; rd_delay = 8; ddrReadData = 16'hBEEF;
        dispReq = 1'b1; dispAddress = 24'h000123;
        tick();
        chk("rd_issue", {31'd0, ddrRead}, 32'd1);
        chk("rd_addr", {8'd0, ddrReadAddress}, 32'h000123);
        wait_ack(1'b0, 50, seen);
        chk("rd_ack_seen", {31'd0, seen}, 32'd1);
        dispReq = 1'b0;
        chk("rd_data", {16'd0, dispData}, 32'h0000BEEF);
        chk("rd_high_cycles", rd_high, 32'd9);
        tick(); tick();
        chk("rd_ack_count", disp_ack_cnt, 32'd1);
        chk("rd_data_held", {16'd0, dispData}, 32'h0000BEEF);

        // Single write
        draw_ack_cnt = 0; wr_delay = 8;
        drawReq = 1'b1; drawAddress = 24'h0A0000; drawData = 16'h1234;
        tick();
        chk("wr_issue", {31'd0, ddrWrite}, 32'd1);
        chk("wr_addr", {8'd0, ddrWriteAddress}, 32'h0A0000);
        chk("wr_data", {16'd0, ddrWriteData}, 32'h1234);
        wait_ack(1'b1, 50, seen);
        chk("wr_ack_seen", {31'd0, seen}, 32'd1);
        drawReq = 1'b0;
        chk("wr_ack_after_fall", {31'd0, ddrWriteAcknowledge}, 32'd0);
        chk("wr_model_addr", {8'd0, m_wr_addr}, 32'h0A0000);
        chk("wr_model_data", {16'd0, m_wr_data}, 32'h1234);
        tick(); tick();
        chk("wr_ack_count", draw_ack_cnt, 32'd1);

        // Both requests held: reads may starve a write for at most four grants
        rd_delay = 2; wr_delay = 2; nlog = 0; disp_ack_cnt = 0; draw_ack_cnt = 0;
        ddrReadData = 16'h5A5A; dispAddress = 24'h000200; drawAddress = 24'h000300;
        dispReq = 1'b1; drawReq = 1'b1;
        for (int i = 0; i < 400 && nlog < 10; i++) tick();
        dispReq = 1'b0; drawReq = 1'b0;
        chk("starve_grants", {31'd0, nlog >= 10}, 32'd1);
        for (int i = 0; i < 10; i++) chk($sformatf("grant_order_%0d", i), {31'd0, grant_log[i]}, {31'd0, exp_seq[i]});
        repeat (20) tick();
        chk("starve_disp_acks", disp_ack_cnt, 32'd8);
        chk("starve_draw_acks", draw_ack_cnt, 32'd2);

        // DDR never answers: abort after 255 cycles
        never_ack = 1'b1; rd_high = 0; disp_ack_cnt = 0;
        dispReq = 1'b1; dispAddress = 24'h000555;
        wait_ack(1'b0, 300, seen);
        chk("tmo_ack_seen", {31'd0, seen}, 32'd1);
        dispReq = 1'b0; never_ack = 1'b0;
        chk("tmo_data_zero", {16'd0, dispData}, 32'd0);
        chk("tmo_error", {31'd0, timeoutError}, 32'd1);
        chk("tmo_rd_high", rd_high, 32'd255);
        tick(); tick();
        chk("tmo_ack_count", disp_ack_cnt, 32'd1);

        // Error stays set across a later good transaction
        ddrReadData = 16'hCAFE; rd_delay = 2; dispReq = 1'b1; dispAddress = 24'h000007;
        wait_ack(1'b0, 50, seen);
        chk("sticky_ack_seen", {31'd0, seen}, 32'd1);
        dispReq = 1'b0;
        chk("sticky_data", {16'd0, dispData}, 32'h0000CAFE);
        chk("sticky_error", {31'd0, timeoutError}, 32'd1);
        tick(); tick();

        // Reset during READ_REQ with a stale ack still high afterwards
        rd_delay = 50; disp_ack_cnt = 0; ddrReadData = 16'h0BAD;
        dispReq = 1'b1; dispAddress = 24'h000042;
        repeat (3) tick();
        chk("mid_rd_active", {31'd0, ddrRead}, 32'd1);
        rst = 1'b1; ack_hold = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_drop", {31'd0, ddrRead}, 32'd0);
        chk("mid_rst_err_clr", {31'd0, timeoutError}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_wait_ack_low", {31'd0, ddrRead}, 32'd0);
        end
        chk("mid_no_ack", disp_ack_cnt, 32'd0);
        rd_delay = 2; ack_hold = 1'b0;
        tick();
        chk("mid_regrant", {31'd0, ddrRead}, 32'd1);
        wait_ack(1'b0, 50, seen);
        chk("mid_ack_seen", {31'd0, seen}, 32'd1);
        dispReq = 1'b0;
        chk("mid_data", {16'd0, dispData}, 32'h00000BAD);
        tick(); tick();
        chk("mid_ack_count", disp_ack_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Parameters
REQ-001 STARVE_LIMIT, default 4, max consecutive display reads granted while a draw write waits.
REQ-002 TIMEOUT, default 255, max cycles spent in one DDR transaction before abort.

Interface
REQ-003 clk133_p  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 dispReq  in  1  display read request; held with dispAddress until dispAck.
REQ-006 dispAddress  in  24  display read word address.
REQ-007 dispAck  out  1  one-cycle pulse: read complete, dispData valid that cycle and held until next capture.
REQ-008 dispData  out  16  display read data.
REQ-009 drawReq  in  1  draw write request; held with drawAddress/drawData until drawAck.
REQ-010 drawAddress  in  24  draw write word address.
REQ-011 drawData  in  16  draw write data.
REQ-012 drawAck  out  1  one-cycle pulse: write complete.
REQ-013 ddrRead  out  1  read request to DDR controller.
REQ-014 ddrReadAddress  out  24  DDR read address.
REQ-015 ddrReadAcknowledge  in  1  DDR read ack; level, stays high until ddrRead drops.
REQ-016 ddrReadData  in  16  DDR read data, valid while ddrReadAcknowledge high.
REQ-017 ddrWrite  out  1  write request to DDR controller.
REQ-018 ddrWriteAddress  out  24  DDR write address.
REQ-019 ddrWriteData  out  16  DDR write data.
REQ-020 ddrWriteAcknowledge  in  1  DDR write ack; level, stays high until ddrWrite drops.
REQ-021 timeoutError  out  1  sticky: a transaction was aborted on timeout.

Function
REQ-022 States SHALL be IDLE, READ_REQ, READ_RELEASE, WRITE_REQ, WRITE_RELEASE, DONE.
REQ-023 IDLE: if dispReq and (not drawReq or starveCount < STARVE_LIMIT) -> READ_REQ; else if drawReq -> WRITE_REQ; else stay.
REQ-024 Grant SHALL latch address (and drawData for writes) into ddr*Address/ddrWriteData and assert ddrRead/ddrWrite the next cycle; latched values SHALL be stable until release.
REQ-025 starveCount (3+ bits, saturating) SHALL increment on each read grant while drawReq high, clear on every write grant, and clear when drawReq low in IDLE.
REQ-026 READ_REQ: on ddrReadAcknowledge high, capture ddrReadData into dispData, drop ddrRead, -> READ_RELEASE.
REQ-027 WRITE_REQ: on ddrWriteAcknowledge high, drop ddrWrite, -> WRITE_RELEASE.
REQ-028 *_RELEASE: wait for the matching DDR ack low, then -> DONE; no new DDR request SHALL be issued while either DDR ack is high.
REQ-029 DONE: assert dispAck or drawAck (per completed op) for exactly one cycle; requests are not evaluated; -> IDLE.
REQ-030 Client SHALL drop req the cycle after ack; req still high in IDLE is a new request.
REQ-031 ddrRead and ddrWrite SHALL never be high in the same cycle.
REQ-032 Timeout counter SHALL clear on grant and increment in REQ/RELEASE states; on reaching TIMEOUT: drop DDR request, set timeoutError, go to DONE and ack the client (dispData = 16'h0000 for aborted read).
REQ-033 Requests arriving during an active transaction SHALL wait; simultaneous dispReq/drawReq in IDLE resolve per REQ-023.

Reset
REQ-034 On rst: state IDLE; dispAck, drawAck, ddrRead, ddrWrite, timeoutError = 0; dispData, ddr*Address, ddrWriteData = 0; starveCount, timeout counter = 0.
REQ-035 rst mid-transaction SHALL drop ddrRead/ddrWrite next edge with no ack issued; after rst, first grant SHALL wait for both DDR acks low.

Verification
REQ-036 dispReq, addr 24'h000123, DDR model acks after 8 cycles with 16'hBEEF -> ddrRead high until ack, dispAck one pulse, dispData=16'hBEEF.
REQ-037 drawReq addr 24'h0A0000 data 16'h1234 -> ddrWriteAddress/Data match, drawAck one pulse after ddrWriteAcknowledge falls.
REQ-038 dispReq and drawReq held continuously -> grant order R,R,R,R,W,R,R,R,R,W.
REQ-039 DDR model never acks -> abort at cycle 255, timeoutError=1 sticky, dispAck pulse with dispData=0.
REQ-040 rst asserted while in READ_REQ -> ddrRead=0 next cycle, no dispAck; next read waits for ddrReadAcknowledge low.
REQ-041 Assertion throughout: ddrRead&ddrWrite never 1; acks never wider than one cycle.
